mod_enc_mixcolumns: RTL and testbench
=====================================

Name: mod_enc_mixcolumns

Overview:
- AES-256 encryption MixColumns stage, directly downstream of the ShiftRows shifter.
- Captures the 16-byte post-ShiftRows state in parallel.
- Computes MixColumns one column per cycle using a shared GF(2^8) column unit.
- Presents the 16-byte result in parallel with a valid/done handshake to the AddRoundKey stage.
- A bypass input supports the final round, which has no MixColumns.

Parameters:
- N, 16, number of state bytes (fixed; not to be overridden).
- NCOL, 4, number of columns and rows in the state.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- inp  input  [15:0][7:0]  state from shifter; byte index = 4*row + col (row-major).
- start  input  1  request to capture inp and begin processing.
- bypass  input  1  sampled with start; 1 = final round, pass the state through unmodified.
- busy  output  1  high while computing; start is ignored while busy.
- done  output  1  single-cycle pulse when outp becomes valid.
- outp_valid  output  1  outp holds a completed result.
- outp  output  [15:0][7:0]  result, same row-major layout as inp.

Behaviour:
- Interface: one clock, clk. Reset resetn is asynchronous and active-low.
- Reset value of every output: 0. That is busy=0, done=0, outp_valid=0, outp=all zero bytes.
- Reset also clears the FSM (to IDLE), the column counter, the captured state and the bypass flag.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1 at edge k:
  - capture inp into the internal state and latch bypass.
  - col counter = 0, outp_valid <= 0, go to CALC.
  - busy is high from edge k.
- CALC, edges k+1..k+4: write column c = col counter into outp bytes c, 4+c, 8+c, 12+c.
  - bypass=0: the written column is {s0,s1,s2,s3} -> MixColumns.
    - b0 = 2s0^3s1^s2^s3
    - b1 = s0^2s1^3s2^s3
    - b2 = s0^s1^2s2^3s3
    - b3 = 3s0^s1^s2^2s3
    - where s0..s3 are rows 0..3 of column c.
  - bypass=1: the column is copied unchanged. Latency is identical to bypass=0.
  - Counter increments each edge. At the edge writing column 3, go to DONE, set outp_valid=1 and done=1.
  - start is ignored in CALC; inp changes in CALC have no effect.
- Latency: start sampled at edge k -> done and outp_valid high after edge k+4.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge: if start=1, behave as IDLE+start (capture, clear outp_valid, go to CALC). Otherwise go to IDLE.
- outp_valid holds at 1 and outp is stable until the next accepted start.
- outp is unspecified-but-stable between acceptance and done; downstream uses it only while outp_valid=1.
- Arithmetic:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - 3a = xtime(a) ^ a.
  - All results are 8-bit; no overflow beyond the field reduction.
- Reset mid-CALC: immediate return to IDLE with all outputs 0. No done is ever produced for the aborted operation.

Decomposition:
- Package aes_enc_pkg holds:
  - typedef state_t = logic [15:0][7:0].
  - typedef col_t = logic [3:0][7:0].
  - constants AES_POLY_RED = 8'h1b, N_STATE = 16, N_COL = 4.
  - enum enc_mix_state_t {IDLE, CALC, DONE}.
- Sub-module mod_enc_mixcol_column: purely combinational, col_t in -> col_t out.
  - Contains xtime and the 2/3 multiplies.
  - Instantiated once and shared across the four columns by the counter mux.

Test Plan:
- Reset then idle -> busy=0, done=0, outp_valid=0, outp all 00. Assert resetn low mid-CALC -> same values immediately, and no done afterwards.
- FIPS-197 column test: column 0 (bytes 0,4,8,12) = db,13,53,45; column 1 = f2,0a,22,5c; column 2 = 01,01,01,01; column 3 = c6,c6,c6,c6; start with bypass=0.
  - Expected columns: 8e,4d,a1,bc; 9f,dc,58,9d; 01,01,01,01; c6,c6,c6,c6.
  - done must pulse exactly 4 cycles after the start edge.
- FIPS-197 round-1 column: column 0 = d4,bf,5d,30 -> 04,66,81,e5.
  - Cross-check the full FIPS-197 round-1 after-ShiftRows state against the published after-MixColumns state.
- bypass=1 with the first-scenario state -> outp equals inp byte-for-byte; done at the same latency.
- Hold start=1 continuously and change inp during CALC:
  - only the state captured in IDLE is processed.
  - the next capture occurs in the DONE cycle.
  - done pulses every 5 cycles.
  - outp_valid drops to 0 one edge after each accepted start.
- Back-to-back operations: result A is held with outp_valid=1 for several idle cycles, then start B.
  - outp_valid falls at B's capture edge.
  - B's result appears with done exactly 4 edges later, with no residue from A.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// Shared types and constants for the AES-256 encryption datapath stages.
package aes_enc_pkg;

    localparam logic [7:0] AES_POLY_RED = 8'h1b;
    localparam int         N_STATE      = 16;
    localparam int         N_COL        = 4;

    typedef logic [15:0][7:0] state_t;
    typedef logic [3:0][7:0]  col_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } enc_mix_state_t;

endpackage

// File: rtl/mod_enc_mixcol_column.sv
// Combinational MixColumns transform of a single column; element 0 is row 0.
module mod_enc_mixcol_column
    import aes_enc_pkg::*;
(
    input  logic [3:0][7:0] col_i,
    output logic [3:0][7:0] col_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    assign col_o[0] = xtime(col_i[0]) ^ mul3(col_i[1]) ^ col_i[2] ^ col_i[3];
    assign col_o[1] = col_i[0] ^ xtime(col_i[1]) ^ mul3(col_i[2]) ^ col_i[3];
    assign col_o[2] = col_i[0] ^ col_i[1] ^ xtime(col_i[2]) ^ mul3(col_i[3]);
    assign col_o[3] = mul3(col_i[0]) ^ col_i[1] ^ col_i[2] ^ xtime(col_i[3]);

endmodule

// File: rtl/mod_enc_mixcolumns.sv
// AES MixColumns stage: captures a row-major state, processes one column per
// cycle through a shared column unit, and holds the result with valid/done.
module mod_enc_mixcolumns
    import aes_enc_pkg::*;
#(
    parameter int N    = N_STATE,
    parameter int NCOL = N_COL
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N-1:0][7:0] inp,
    input  logic              start,
    input  logic              bypass,
    output logic              busy,
    output logic              done,
    output logic              outp_valid,
    output logic [N-1:0][7:0] outp
);

    localparam int COL_W = $clog2(NCOL);

    enc_mix_state_t    fsm_q, fsm_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [N-1:0][7:0] state_q, state_d;
    logic              bypass_q, bypass_d;
    logic [N-1:0][7:0] outp_q, outp_d;
    logic              outp_valid_q, outp_valid_d;

    logic [3:0][7:0]   col_in;
    logic [3:0][7:0]   col_mixed;
    logic [3:0][7:0]   col_wr;

    // The column selected by the counter feeds the single shared transform.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < NCOL; r++) begin
            col_in[r] = state_q[NCOL*r + int'(col_q)];
        end
    end

    mod_enc_mixcol_column u_column (
        .col_i (col_in),
        .col_o (col_mixed)
    );

    assign col_wr = bypass_q ? col_in : col_mixed;

    always_comb begin
        fsm_d        = fsm_q;
        col_d        = col_q;
        state_d      = state_q;
        bypass_d     = bypass_q;
        outp_d       = outp_q;
        outp_valid_d = outp_valid_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = inp;
                    bypass_d     = bypass;
                    col_d        = '0;
                    outp_valid_d = 1'b0;
                    fsm_d        = CALC;
                end else begin
                    fsm_d        = IDLE;
                end
            end
            CALC: begin
                for (int r = 0; r < NCOL; r++) begin
                    outp_d[NCOL*r + int'(col_q)] = col_wr[r];
                end
                col_d = col_q + 1'b1;
                if (col_q == COL_W'(NCOL - 1)) begin
                    fsm_d        = DONE;
                    outp_valid_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q        <= IDLE;
            col_q        <= '0;
            state_q      <= '0;
            bypass_q     <= 1'b0;
            outp_q       <= '0;
            outp_valid_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            col_q        <= col_d;
            state_q      <= state_d;
            bypass_q     <= bypass_d;
            outp_q       <= outp_d;
            outp_valid_q <= outp_valid_d;
        end
    end

    assign busy       = (fsm_q == CALC);
    assign done       = (fsm_q == DONE);
    assign outp_valid = outp_valid_q;
    assign outp       = outp_q;

endmodule

// File: tb/tb_mod_enc_mixcolumns.sv
// Directed bench for the MixColumns stage: FIPS-197 vectors, bypass, held
// start, back-to-back operation and reset during computation.
module tb_mod_enc_mixcolumns;
    import aes_enc_pkg::*;

    typedef struct {
        state_t vin;
        logic   byp;
        state_t vexp;
    } vec_t;

    logic   clk;
    logic   resetn;
    state_t inp;
    logic   start;
    logic   bypass;
    logic   busy;
    logic   done;
    logic   outp_valid;
    state_t outp;

    int checks;
    int errors;
    vec_t vecs[5];

    mod_enc_mixcolumns dut (
        .clk        (clk),
        .resetn     (resetn),
        .inp        (inp),
        .start      (start),
        .bypass     (bypass),
        .busy       (busy),
        .done       (done),
        .outp_valid (outp_valid),
        .outp       (outp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic col_t col4(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3);
        col_t c;
        c[0] = b0;
        c[1] = b1;
        c[2] = b2;
        c[3] = b3;
        return c;
    endfunction

    // Columns are given top-to-bottom; the state is row-major (4*row+col).
    function automatic state_t make_state(input col_t c0, input col_t c1,
                                          input col_t c2, input col_t c3);
        state_t s;
        col_t   cols[4];
        cols[0] = c0;
        cols[1] = c1;
        cols[2] = c2;
        cols[3] = c3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[4*r + c] = cols[c][r];
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one vector, then watch exact latency and the held result.
    task automatic applyStimulus(input vec_t v, input string tag);
        inp    = v.vin;
        bypass = v.byp;
        start  = 1'b1;
        tick();
        checkOutput({tag, " busy@k"}, 128'(busy), 128'(1));
        checkOutput({tag, " valid@k"}, 128'(outp_valid), 128'(0));
        checkOutput({tag, " done@k"}, 128'(done), 128'(0));
        start  = 1'b0;
        bypass = ~v.byp;
        inp    = ~v.vin;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e < 4)
                checkOutput({tag, " early done"}, 128'(done), 128'(0));
        end
        checkOutput({tag, " done@k+4"}, 128'(done), 128'(1));
        checkOutput({tag, " valid@k+4"}, 128'(outp_valid), 128'(1));
        checkOutput({tag, " busy@k+4"}, 128'(busy), 128'(0));
        checkOutput({tag, " outp"}, outp, v.vexp);
        for (int e = 0; e < 3; e++) begin
            tick();
            checkOutput({tag, " done held low"}, 128'(done), 128'(0));
            checkOutput({tag, " valid held"}, 128'(outp_valid), 128'(1));
            checkOutput({tag, " outp held"}, outp, v.vexp);
        end
    endtask

    initial begin
        state_t junk;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        start  = 1'b0;
        bypass = 1'b0;
        inp    = '0;

        vecs[0].vin  = make_state(col4(8'hdb, 8'h13, 8'h53, 8'h45), col4(8'hf2, 8'h0a, 8'h22, 8'h5c),
                                  col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'hc6, 8'hc6, 8'hc6, 8'hc6));
        vecs[0].byp  = 1'b0;
        vecs[0].vexp = make_state(col4(8'h8e, 8'h4d, 8'ha1, 8'hbc), col4(8'h9f, 8'hdc, 8'h58, 8'h9d),
                                  col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'hc6, 8'hc6, 8'hc6, 8'hc6));
        vecs[1].vin  = make_state(col4(8'hd4, 8'hbf, 8'h5d, 8'h30), col4(8'he0, 8'hb4, 8'h52, 8'hae),
                                  col4(8'hb8, 8'h41, 8'h11, 8'hf1), col4(8'h1e, 8'h27, 8'h98, 8'he5));
        vecs[1].byp  = 1'b0;
        vecs[1].vexp = make_state(col4(8'h04, 8'h66, 8'h81, 8'he5), col4(8'he0, 8'hcb, 8'h19, 8'h9a),
                                  col4(8'h48, 8'hf8, 8'hd3, 8'h7a), col4(8'h28, 8'h06, 8'h26, 8'h4c));
        vecs[2].vin  = vecs[0].vin;
        vecs[2].byp  = 1'b1;
        vecs[2].vexp = vecs[0].vin;
        vecs[3].vin  = make_state(col4(8'hd4, 8'hd4, 8'hd4, 8'hd5), col4(8'h2d, 8'h26, 8'h31, 8'h4c),
                                  col4(8'h00, 8'h00, 8'h00, 8'h00), col4(8'hff, 8'hff, 8'hff, 8'hff));
        vecs[3].byp  = 1'b0;
        vecs[3].vexp = make_state(col4(8'hd5, 8'hd5, 8'hd7, 8'hd6), col4(8'h4d, 8'h7e, 8'hbd, 8'hf8),
                                  col4(8'h00, 8'h00, 8'h00, 8'h00), col4(8'hff, 8'hff, 8'hff, 8'hff));
        vecs[4].vin  = vecs[1].vin;
        vecs[4].byp  = 1'b1;
        vecs[4].vexp = vecs[1].vin;

        repeat (3) tick();
        resetn = 1'b1;
        tick();
        tick();
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset done", 128'(done), 128'(0));
        checkOutput("reset valid", 128'(outp_valid), 128'(0));
        checkOutput("reset outp", outp, 128'(0));

        for (int i = 0; i < 5; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // start held high: capture in IDLE, next capture in the DONE cycle.
        junk   = make_state(col4(8'h11, 8'h22, 8'h33, 8'h44), col4(8'h55, 8'h66, 8'h77, 8'h88),
                            col4(8'h99, 8'haa, 8'hbb, 8'hcc), col4(8'hdd, 8'hee, 8'hff, 8'h01));
        inp    = vecs[0].vin;
        bypass = 1'b0;
        start  = 1'b1;
        tick();
        inp = junk;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checkOutput($sformatf("held done@%0d", e), 128'(done),
                        128'((e == 4 || e == 9) ? 1 : 0));
            if (e == 4) begin
                checkOutput("held outp A", outp, vecs[0].vexp);
                inp = vecs[1].vin;
            end
            if (e == 5) begin
                checkOutput("held valid drop", 128'(outp_valid), 128'(0));
                checkOutput("held busy", 128'(busy), 128'(1));
                inp = junk;
            end
            if (e == 9) begin
                checkOutput("held outp B", outp, vecs[1].vexp);
                checkOutput("held valid B", 128'(outp_valid), 128'(1));
                start = 1'b0;
            end
        end
        checkOutput("held back to idle", 128'(busy), 128'(0));

        // Reset during computation aborts with no done.
        inp   = vecs[3].vin;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        checkOutput("abort busy", 128'(busy), 128'(0));
        checkOutput("abort done", 128'(done), 128'(0));
        checkOutput("abort valid", 128'(outp_valid), 128'(0));
        checkOutput("abort outp", outp, 128'(0));
        tick();
        resetn = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            checkOutput("no done after abort", 128'(done), 128'(0));
            checkOutput("no valid after abort", 128'(outp_valid), 128'(0));
        end

        applyStimulus(vecs[3], "post-abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
